mul8_seq_ctrl: RTL

Sequencing controller that computes an unsigned 8x8 -> 16-bit product by time-multiplexing the existing 4x4 combinational multiplier (`wallace_tree`) over four partial-product steps. It accepts operands over a valid/ready handshake and accumulates shifted partial products in a 16-bit register. It presents the result over a second valid/ready handshake with backpressure. It sits between any requester needing byte-wide multiplication and the single shared 4x4 multiplier core.

---
 rtl/mul8_seq_pkg.sv | 34 +++
 rtl/mul8_seq_ctrl_if.sv | 23 ++
 rtl/wallace_tree.sv | 16 +
 rtl/mul8_seq_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/mul8_seq_pkg.sv
// Shared definitions for the sequential 8x8 multiplier built on the 4x4 core.
package mul8_seq_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned STEP_W = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } state_t;

    // Step order: low*low, high*low, low*high, high*high.
    localparam logic [STEP_W-1:0] STEP_LL = 2'd0;
    localparam logic [STEP_W-1:0] STEP_HL = 2'd1;
    localparam logic [STEP_W-1:0] STEP_LH = 2'd2;
    localparam logic [STEP_W-1:0] STEP_HH = 2'd3;

    // Left shift applied to the partial product of each step.
    function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
        logic [3:0] sh;
        unique case (step)
            STEP_LL: sh = 4'd0;
            STEP_HL: sh = 4'd4;
            STEP_LH: sh = 4'd4;
            STEP_HH: sh = 4'd8;
            default: sh = 4'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mul8_seq_ctrl_if.sv
// Operand and result handshakes of mul8_seq_ctrl.
interface mul8_seq_ctrl_if;
    import mul8_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] p;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p
    );

endinterface

// File: rtl/wallace_tree.sv
// Existing purely combinational unsigned 4x4 -> 8 multiplier core.
module wallace_tree (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] z
);

    // Sum of the four shifted partial-product rows.
    always_comb begin
        z = 8'd0;
        for (int i = 0; i < 4; i++) begin
            z = z + ({4'd0, x & {4{y[i]}}} << i);
        end
    end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequential unsigned 8x8 multiplier: four passes through a shared 4x4 core,
// accumulating shifted partial products into a 16-bit register.
// Optional macro MUL8_SEQ_ZSKIP_EN: a zero operand skips straight to DONE.
module mul8_seq_ctrl
    import mul8_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    mul8_seq_ctrl_if.slave  bus
);

    state_t              state_q;
    logic [STEP_W-1:0]   step_q;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;
    logic [PROD_W-1:0]   acc_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic [NIB_W-1:0]    nib_a;
    logic [NIB_W-1:0]    nib_b;
    logic [2*NIB_W-1:0]  pp;
    logic [PROD_W-1:0]   pp_shifted;
    logic [PROD_W-1:0]   acc_sum;

    // Nibble select for the core, driven from registered operands and step.
    always_comb begin
        nib_a = a_q[NIB_W-1:0];
        nib_b = b_q[NIB_W-1:0];
        unique case (step_q)
            STEP_LL: begin nib_a = a_q[NIB_W-1:0];    nib_b = b_q[NIB_W-1:0];    end
            STEP_HL: begin nib_a = a_q[OP_W-1:NIB_W]; nib_b = b_q[NIB_W-1:0];    end
            STEP_LH: begin nib_a = a_q[NIB_W-1:0];    nib_b = b_q[OP_W-1:NIB_W]; end
            STEP_HH: begin nib_a = a_q[OP_W-1:NIB_W]; nib_b = b_q[OP_W-1:NIB_W]; end
            default: ;
        endcase
    end

    wallace_tree u_core (
        .x (nib_a),
        .y (nib_b),
        .z (pp)
    );

    // Shift the partial product into place and add to the accumulator.
    always_comb begin
        pp_shifted = PROD_W'(pp) << step_shift(step_q);
        acc_sum    = acc_q + pp_shifted;
    end

    // Control FSM with step counter, operand capture and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            step_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        acc_q      <= '0;
                        step_q     <= STEP_LL;
                        in_ready_q <= 1'b0;
`ifdef MUL8_SEQ_ZSKIP_EN
                        if (bus.a == '0 || bus.b == '0) begin
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= StMul;
                        end
`else
                        state_q <= StMul;
`endif
                    end
                end
                StMul: begin
                    acc_q  <= acc_sum;
                    step_q <= step_q + 1'b1;
                    if (step_q == STEP_HH) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // acc only changes in IDLE (cleared) and MUL, so p is stable in DONE.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.p         = acc_q;

endmodule
